// File: rtl/mysystem_ram_arbiter.sv
// rtl/mysystem_ram_arbiter.sv - two-port round-robin arbiter in front of a single-port RAM
module mysystem_ram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);

    logic pend0;
    logic pend1;
    logic grant0;
    logic grant1;
    logic any_grant;
    logic grant_write;
    logic grant_read;
    logic last_grant;   // index of the port granted most recently
    logic rd_pend;      // a read was presented to the RAM last cycle
    logic rd_owner;     // port that owns the outstanding read

    assign pend0 = m0_read | m0_write;
    assign pend1 = m1_read | m1_write;

    // Round-robin grant: on contention the port not granted last wins; nothing is granted in reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (pend0 && pend1) begin
                if (last_grant) grant0 = 1'b1;
                else            grant1 = 1'b1;
            end else if (pend0) begin
                grant0 = 1'b1;
            end else if (pend1) begin
                grant1 = 1'b1;
            end
        end
    end

    assign any_grant   = grant0 | grant1;
    // Write dominates when a port raises read and write together.
    assign grant_write = grant1 ? m1_write : (grant0 & m0_write);
    assign grant_read  = any_grant & ~grant_write;

    assign m0_waitrequest = reset | (pend0 & ~grant0);
    assign m1_waitrequest = reset | (pend1 & ~grant1);

    // RAM request mux: port 1 only when it holds the grant, otherwise port 0 passes through.
    always_comb begin
        ram_address    = m0_address;
        ram_byteenable = m0_byteenable;
        ram_writedata  = m0_writedata;
        if (grant1) begin
            ram_address    = m1_address;
            ram_byteenable = m1_byteenable;
            ram_writedata  = m1_writedata;
        end
        if (grant_read) begin
            ram_byteenable = '1;
        end
        ram_chipselect = any_grant;
        ram_write      = grant_write;
    end

    assign ram_clken = ~reset;

    // Arbitration history and one-cycle read-return tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            if (any_grant) begin
                last_grant <= grant1;
            end
            rd_pend <= grant_read;
            if (grant_read) begin
                rd_owner <= grant1;
            end
        end
    end

    assign m0_readdatavalid = rd_pend & ~rd_owner;
    assign m1_readdatavalid = rd_pend &  rd_owner;
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;

endmodule

// File: tb/tb_mysystem_ram_arbiter.sv
// tb/tb_mysystem_ram_arbiter.sv - directed self-checking bench for mysystem_ram_arbiter
module tb_mysystem_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [11:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata = 32'h0;

    logic [31:0] mem [0:4095];

    int n_cmp  = 0;
    int n_fail = 0;
    int cnt0;
    int cnt1;

    always #5 clk = ~clk;

    mysystem_ram_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
    );

    // One-cycle-latency byte-writable RAM behind the arbiter.
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
                end
            end
            ram_readdata <= mem[ram_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[12'h010] = 32'h1111_0010;
        mem[12'h020] = 32'h2222_0020;
        mem[12'h033] = 32'h1234_5678;
        mem[12'h040] = 32'h4444_0040;
        mem[12'h080] = 32'h8888_0080;

        reset = 1'b1;
        idle_all();
        m0_address = '0; m1_address = '0;
        m0_byteenable = '0; m1_byteenable = '0;
        m0_writedata = '0; m1_writedata = '0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);
        chk("rst_clken", ram_clken, 0);
        chk("rst_cs", ram_chipselect, 0);
        chk("rst_wr", ram_write, 0);
        chk("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
        @(negedge clk); reset = 1'b0; #1;
        chk("clken_on", ram_clken, 1);
        chk("idle_m0_wait", m0_waitrequest, 0);

        // Simultaneous reads: m0 first, then m1, each returning one clk later
        @(negedge clk);
        m0_address = 12'h010; m0_read = 1'b1;
        m1_address = 12'h020; m1_read = 1'b1;
        #1;
        chk("c0_m0_wait", m0_waitrequest, 0);
        chk("c0_m1_wait", m1_waitrequest, 1);
        chk("c0_addr", ram_address, 12'h010);
        chk("c0_cs", ram_chipselect, 1);
        chk("c0_be", ram_byteenable, 4'hF);
        @(negedge clk); m0_read = 1'b0; #1;
        chk("c1_m1_wait", m1_waitrequest, 0);
        chk("c1_addr", ram_address, 12'h020);
        chk("c1_m0_rdv", m0_readdatavalid, 1);
        chk("c1_m0_rdata", m0_readdata, 32'h1111_0010);
        chk("c1_m1_rdv", m1_readdatavalid, 0);
        @(negedge clk); m1_read = 1'b0; #1;
        chk("c2_m1_rdv", m1_readdatavalid, 1);
        chk("c2_m1_rdata", m1_readdata, 32'h2222_0020);
        chk("c2_m0_rdv", m0_readdatavalid, 0);
        chk("c2_cs", ram_chipselect, 0);

        // Idle: RAM outputs follow port 0
        m0_address = 12'h123; m1_address = 12'h456; m0_byteenable = 4'h6; #1;
        chk("idle_addr", ram_address, 12'h123);
        chk("idle_be", ram_byteenable, 4'h6);

        // m0 write then read back
        @(negedge clk);
        m0_address = 12'h005; m0_writedata = 32'hDEAD_BEEF; m0_byteenable = 4'hF; m0_write = 1'b1;
        #1;
        chk("w0_wr", ram_write, 1);
        chk("w0_wdata", ram_writedata, 32'hDEAD_BEEF);
        chk("w0_wait", m0_waitrequest, 0);
        @(negedge clk); m0_write = 1'b0; m0_read = 1'b1; #1;
        chk("w0_no_rdv", m0_readdatavalid, 0);
        chk("r0_wr", ram_write, 0);
        @(negedge clk); m0_read = 1'b0; #1;
        chk("r0_rdv", m0_readdatavalid, 1);
        chk("r0_rdata", m0_readdata, 32'hDEAD_BEEF);

        // m1 single-byte write into preloaded word
        @(negedge clk);
        m1_address = 12'h033; m1_writedata = 32'h0000_00AA; m1_byteenable = 4'h1; m1_write = 1'b1;
        #1;
        chk("w1_be", ram_byteenable, 4'h1);
        chk("w1_addr", ram_address, 12'h033);
        @(negedge clk); m1_write = 1'b0; m1_read = 1'b1; #1;
        chk("r1_be", ram_byteenable, 4'hF);
        @(negedge clk); m1_read = 1'b0; #1;
        chk("r1_rdv", m1_readdatavalid, 1);
        chk("r1_rdata", m1_readdata, 32'h1234_56AA);

        // Continuous contention for 8 cycles, last grant was m1 so m0 leads
        cnt0 = 0; cnt1 = 0;
        m0_address = 12'h040; m1_address = 12'h080;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            m0_read = (i < 8); m1_read = (i < 8);
            #1;
            if (i < 8) begin
                chk("rr_m0_wait", m0_waitrequest, (i % 2 == 1));
                chk("rr_m1_wait", m1_waitrequest, (i % 2 == 0));
                chk("rr_cs", ram_chipselect, 1);
            end
            if (m0_readdatavalid) begin
                cnt0++;
                chk("rr_m0_rdata", m0_readdata, 32'h4444_0040);
            end
            if (m1_readdatavalid) begin
                cnt1++;
                chk("rr_m1_rdata", m1_readdata, 32'h8888_0080);
            end
        end
        chk("rr_cnt0", cnt0, 4);
        chk("rr_cnt1", cnt1, 4);

        // Reset while a read is outstanding
        @(negedge clk); m0_address = 12'h010; m0_read = 1'b1; #1;
        chk("rs_m0_wait", m0_waitrequest, 0);
        @(posedge clk); #1;
        reset = 1'b1; m0_read = 1'b0;
        #1;
        chk("rs_rdv_clr", m0_readdatavalid, 0);
        chk("rs_wait", m0_waitrequest, 1);
        @(posedge clk); #1; reset = 1'b0; #1;
        chk("rs_rdv_after", m0_readdatavalid, 0);
        @(negedge clk);
        m0_read = 1'b1; m1_read = 1'b1; m1_address = 12'h020; #1;
        chk("rs_first_m0", m0_waitrequest, 0);
        chk("rs_first_m1", m1_waitrequest, 1);
        chk("rs_rdv_none", m0_readdatavalid, 0);
        @(negedge clk); m0_read = 1'b0; #1;
        @(negedge clk); m1_read = 1'b0; #1;

        // m1 read and write together at top address: treated as write
        @(negedge clk);
        m1_address = 12'hFFF; m1_writedata = 32'hCAFE_0001; m1_byteenable = 4'h3;
        m1_read = 1'b1; m1_write = 1'b1;
        #1;
        chk("rw_wr", ram_write, 1);
        chk("rw_addr", ram_address, 12'hFFF);
        chk("rw_be", ram_byteenable, 4'h3);
        chk("rw_wait", m1_waitrequest, 0);
        @(negedge clk); idle_all(); #1;
        chk("rw_no_rdv", m1_readdatavalid, 0);

        // Lone m1 granted even though m1 was granted last
        @(negedge clk); m1_address = 12'h020; m1_read = 1'b1; #1;
        chk("lone_m1_wait", m1_waitrequest, 0);
        chk("lone_m1_addr", ram_address, 12'h020);
        @(negedge clk); idle_all(); #1;
        chk("lone_m1_rdv", m1_readdatavalid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
